inc_word_fifo: RTL

Elastic buffer that sits directly downstream of the 13-bit registered increment stage. It captures each produced word under a valid/ready handshake, holds up to DEPTH words in order, and presents them to the next consumer. It also reports occupancy and, optionally, the largest word accepted since reset. It decouples the increment stage, which produces a word every cycle, from a consumer that may stall.

---
 rtl/inc_word_fifo.sv | 82 ++++++++
 1 files changed

// File: rtl/inc_word_fifo.sv
// Elastic word buffer behind the 13-bit increment stage: valid/ready FIFO with occupancy count.
// Define PEAK_TRACK_EN to add the max_seen port tracking the largest accepted word.
module inc_word_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             n0,
    input  logic             n1,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    count
`ifdef PEAK_TRACK_EN
    ,
    output logic [WIDTH-1:0] max_seen
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             push_c;
    logic             pop_c;

    assign push_c = in_valid & in_ready;
    assign pop_c  = out_valid & out_ready;

    // Head word comes straight from storage; a fresh push is never bypassed.
    assign out_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push_c && !pop_c) begin
            count_nxt = count + CW'(1);
        end else if (pop_c && !push_c) begin
            count_nxt = count - CW'(1);
        end
    end

    // Flags are registered from the next count so they track count exactly.
    always_ff @(posedge n0 or posedge n1) begin
        if (n1) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            if (push_c) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count     <= count_nxt;
            in_ready  <= (count_nxt != CW'(DEPTH));
            out_valid <= (count_nxt != CW'(0));
        end
    end

`ifdef PEAK_TRACK_EN
    always_ff @(posedge n0 or posedge n1) begin
        if (n1) begin
            max_seen <= '0;
        end else if (push_c && (in_data > max_seen)) begin
            max_seen <= in_data;
        end
    end
`endif

endmodule
